// File: rtl/ex_div_pkg.sv
// -----------------------------------------------------------------------------
// ex_div_pkg
// Purpose : Shared definitions for the iterative divider and the pipeline
//           controller that drives it: FSM state encoding and the default
//           operand width.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package ex_div_pkg;

  // Default operand width; the controller sizes its operand buses from this.
  localparam int EX_DIV_WIDTH = 32;

  // Divider FSM states. The controller decodes these when it inspects the
  // divider, so the encoding is fixed here rather than left to synthesis.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_if.sv
// -----------------------------------------------------------------------------
// ex_div_if
// Purpose : Request/response bundle between the issuing pipeline stage
//           (master) and the divider (slave).
// Signals : signed_div_i  1 = two's complement divide, 0 = unsigned
//           opdata1_i     dividend
//           opdata2_i     divisor
//           start_i       request, held until ready_o is seen
//           annul_i       cancel the operation in flight
//           result_o      {remainder, quotient}
//           ready_o       result_o valid
//           busy_o        operation in progress (pipeline stall request)
// -----------------------------------------------------------------------------
interface ex_div_if #(
  parameter int WIDTH = ex_div_pkg::EX_DIV_WIDTH
);

  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o,
    input  busy_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o,
    output busy_o
  );

endinterface

// File: rtl/ex_div_step.sv
// -----------------------------------------------------------------------------
// ex_div_step
// Purpose : One restoring-division iteration (purely combinational). Shifts
//           the next dividend bit into the partial remainder, trial-subtracts
//           the divisor and keeps the difference if it did not go negative.
// Ports   : rem_i          current partial remainder (always < divisor_i)
//           dividend_bit_i next dividend bit, MSB first
//           divisor_i      divisor magnitude
//           rem_o          next partial remainder
//           quo_bit_o      quotient bit produced by this step
// -----------------------------------------------------------------------------
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // The shifted remainder needs one extra bit; because rem_i < divisor_i the
  // trial value is below 2*divisor_i, so diff[WIDTH] is a clean borrow flag.
  assign trial = {rem_i, dividend_bit_i};
  assign diff  = trial - {1'b0, divisor_i};

  always_comb begin
    quo_bit_o = ~diff[WIDTH];
    rem_o     = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div.sv
// -----------------------------------------------------------------------------
// ex_div
// Purpose : Multi-cycle signed/unsigned integer divider for the EX stage.
//           Restoring algorithm, one quotient bit per clock, WIDTH steps.
//           Signed operands are divided as magnitudes and the signs are fixed
//           up on the final step (all arithmetic modulo 2^WIDTH, so MIN / -1
//           simply wraps to MIN with remainder 0).
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset
//           bus   ex_div_if slave: operands, start/annul, result/ready/busy
// Timing  : start sampled at edge t -> ready_o high after edge t+WIDTH+1
//           (t+2 for divide-by-zero). ready_o, busy_o and result_o are
//           registered, one cycle behind the state they report.
// -----------------------------------------------------------------------------
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = EX_DIV_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  ex_div_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;      // partial remainder, final remainder in END
  logic [WIDTH-1:0]    quo_q, quo_d;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]    dvsr_q, dvsr_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [WIDTH-1:0]    step_rem;
  logic                step_qbit;
  logic [WIDTH-1:0]    quo_shift;
  logic                dvd_neg;
  logic                dvs_neg;

  ex_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (quo_q[WIDTH-1]),
    .divisor_i      (dvsr_q),
    .rem_o          (step_rem),
    .quo_bit_o      (step_qbit)
  );

  // The dividend register doubles as the quotient register: each step
  // consumes its MSB and appends the new quotient bit at the LSB.
  assign quo_shift = {quo_q[WIDTH-2:0], step_qbit};

  assign dvd_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign dvs_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, datapath and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          state_d   = (bus.opdata2_i == '0) ? ST_DIVZERO : ST_ON;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = dvd_neg ? -bus.opdata1_i : bus.opdata1_i;
          dvsr_d    = dvs_neg ? -bus.opdata2_i : bus.opdata2_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
        end
      end

      ST_DIVZERO: begin
        if (bus.annul_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_END;
          rem_d   = '0;
          quo_d   = '0;
        end
      end

      ST_ON: begin
        if (bus.annul_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = quo_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Last bit: apply sign correction to the step output directly so
            // END holds the final answer.
            state_d = ST_END;
            rem_d   = neg_rem_q ? -step_rem  : step_rem;
            quo_d   = neg_quo_q ? -quo_shift : quo_shift;
          end
        end
      end

      ST_END: begin
        // annul is deliberately not looked at here: the result is already
        // committed and only the issuing stage dropping start releases it.
        if (!bus.start_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered and describe the state being left/held, but
    // drop immediately on the edge that leaves END or annuls the operation.
    ready_d  = (state_q == ST_END) && (state_d == ST_END);
    result_d = ready_d ? {rem_q, quo_q} : '0;
    busy_d   = ((state_q == ST_DIVZERO) || (state_q == ST_ON)) && !bus.annul_i;
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_ex_div.sv
// -----------------------------------------------------------------------------
// tb_ex_div
// Purpose : Self-checking bench for ex_div at WIDTH=32 and WIDTH=8. Expected
//           results, latencies and busy counts are queued when an operation
//           is issued and compared when ready_o appears.
// -----------------------------------------------------------------------------
module tb_ex_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_div_if #(.WIDTH(32)) if32 ();
  ex_div_if #(.WIDTH(8))  if8 ();

  ex_div #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  ex_div #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  typedef struct {
    string        tag;
    logic [127:0] res;
    int           lat;
    int           busy_n;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference divide computed with 64-bit arithmetic (truncating division,
  // remainder takes the dividend's sign), then wrapped to 32 bits.
  function automatic logic [63:0] model32(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic drive(input bit w8, input bit s, input logic [63:0] a, input logic [63:0] b,
                       input bit st, input bit an);
    if (w8) begin
      if8.signed_div_i = s;
      if8.opdata1_i    = a[7:0];
      if8.opdata2_i    = b[7:0];
      if8.start_i      = st;
      if8.annul_i      = an;
    end else begin
      if32.signed_div_i = s;
      if32.opdata1_i    = a[31:0];
      if32.opdata2_i    = b[31:0];
      if32.start_i      = st;
      if32.annul_i      = an;
    end
  endtask

  task automatic push_exp(input string tag, input logic [127:0] res, input int lat, input int busy_n);
    exp_t e;
    e.tag    = tag;
    e.res    = res;
    e.lat    = lat;
    e.busy_n = busy_n;
    sb_q.push_back(e);
  endtask

  task automatic start_op(input bit w8, input bit s, input logic [63:0] a, input logic [63:0] b,
                          input string tag, input logic [127:0] res, input int lat, input int busy_n);
    @(negedge clk);
    drive(w8, s, a, b, 1'b1, 1'b0);
    push_exp(tag, res, lat, busy_n);
  endtask

  // Called right after the accept edge's inputs are set: the first negedge
  // seen here follows edge t, so loop index n is "after edge t+n".
  task automatic collect(input bit w8);
    exp_t         e;
    int           lat;
    int           busy_n;
    bit           ok;
    logic [127:0] res;
    e      = sb_q.pop_front();
    lat    = 0;
    busy_n = 0;
    ok     = 1'b0;
    res    = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (w8 ? if8.busy_o : if32.busy_o) busy_n++;
      if (w8 ? if8.ready_o : if32.ready_o) begin
        lat = n;
        res = w8 ? 128'(if8.result_o) : 128'(if32.result_o);
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val({e.tag, "_timeout"}, 128'(0), 128'(1));
    end else begin
      check_val({e.tag, "_result"}, res, e.res);
      check_val({e.tag, "_latency"}, 128'(lat), 128'(e.lat));
      check_val({e.tag, "_busy_cycles"}, 128'(busy_n), 128'(e.busy_n));
    end
    $display("op %s: result=%0h latency=%0d busy=%0d", e.tag, res, lat, busy_n);
    if (w8) if8.start_i = 1'b0;
    else    if32.start_i = 1'b0;
    @(negedge clk);
    check_val({e.tag, "_exit_ready"}, 128'(w8 ? if8.ready_o : if32.ready_o), 128'(0));
  endtask

  initial begin
    int          seen;
    logic [31:0] ra, rb;
    bit          rs;

    rst = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("reset_ready", 128'(if32.ready_o), 128'(0));
    check_val("reset_busy", 128'(if32.busy_o), 128'(0));
    check_val("reset_result", 128'(if32.result_o), 128'(0));
    check_val("reset_ready_w8", 128'(if8.ready_o), 128'(0));
    rst = 1'b0;

    // Directed 32-bit cases
    start_op(1'b0, 1'b0, 64'd100, 64'd7, "u100_7", {32'd2, 32'd14}, 33, 32);
    collect(1'b0);
    start_op(1'b0, 1'b1, 64'hFFFF_FFF9, 64'd2, "s-7_2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 32);
    collect(1'b0);
    start_op(1'b0, 1'b1, 64'd7, 64'hFFFF_FFFE, "s7_-2", {32'd1, 32'hFFFF_FFFD}, 33, 32);
    collect(1'b0);
    start_op(1'b0, 1'b0, 64'd5, 64'd0, "u5_0", 128'd0, 2, 1);
    collect(1'b0);
    start_op(1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "smin_-1", {32'd0, 32'h8000_0000}, 33, 32);
    collect(1'b0);

    // Random operands checked against the 64-bit reference
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 2) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd3;
      rs = i[0];
      start_op(1'b0, rs, 64'(ra), 64'(rb), $sformatf("rnd%0d", i), 128'(model32(rs, ra, rb)), 33, 32);
      collect(1'b0);
    end

    // Annul on the 10th ON cycle
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd1000, 64'd3, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_val("annul_busy_before", 128'(if32.busy_o), 128'(1));
    if32.annul_i = 1'b1;
    if32.start_i = 1'b0;
    @(negedge clk);
    check_val("annul_busy_after", 128'(if32.busy_o), 128'(0));
    check_val("annul_ready_after", 128'(if32.ready_o), 128'(0));
    if32.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.ready_o) seen++;
    end
    check_val("annul_no_ready", 128'(seen), 128'(0));
    $display("op annul: ready cycles seen=%0d", seen);
    start_op(1'b0, 1'b0, 64'd9, 64'd3, "u9_3", {32'd0, 32'd3}, 33, 32);
    collect(1'b0);

    // Reset in the middle of ON, start held through it
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd12345, 64'd67, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_ready", 128'(if32.ready_o), 128'(0));
    check_val("rst_mid_busy", 128'(if32.busy_o), 128'(0));
    check_val("rst_mid_result", 128'(if32.result_o), 128'(0));
    $display("op rst_mid: ready=%0b busy=%0b result=%0h", if32.ready_o, if32.busy_o, if32.result_o);
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'd500, 64'd25, 1'b1, 1'b0);
    push_exp("post_rst_u500_25", {32'd0, 32'd20}, 33, 32);
    collect(1'b0);

    // 8-bit instance
    start_op(1'b1, 1'b0, 64'hFF, 64'h10, "w8_uFF_10", {8'h0F, 8'h0F}, 9, 8);
    collect(1'b1);
    start_op(1'b1, 1'b1, 64'h80, 64'hFF, "w8_smin_-1", {8'h00, 8'h80}, 9, 8);
    collect(1'b1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width in bits (legal values 8..64).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned.
REQ-005 opdata1_i  input  WIDTH  dividend.
REQ-006 opdata2_i  input  WIDTH  divisor.
REQ-007 start_i  input  1  request a divide; held high by the issuing stage until ready_o is seen.
REQ-008 annul_i  input  1  cancel the operation in progress (e.g. branch flush).
REQ-009 result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
REQ-010 ready_o  output  1  result_o valid.
REQ-011 busy_o  output  1  operation in progress; used by the pipeline as a stall request.

Function
REQ-012 The block SHALL be a four-state FSM: IDLE, DIVZERO, ON, END; all outputs registered.
REQ-013 IDLE: start_i=1 and annul_i=0 SHALL go to DIVZERO if opdata2_i==0, else to ON; operands are latched on that edge.
REQ-014 IDLE: start_i=0 or annul_i=1 SHALL stay in IDLE with ready_o=0, result_o=0.
REQ-015 On entry to ON, the block SHALL latch |dividend| and |divisor| when signed_div_i=1 (raw values otherwise), and clear the iteration counter.
REQ-016 ON: one restoring shift/trial-subtract step per cycle, one quotient bit per step, exactly WIDTH steps.
REQ-017 After the WIDTH-th step the block SHALL go to END with sign correction applied: quotient negated if signed and operand signs differ; remainder negated if signed and the dividend is negative.
REQ-018 Negation and absolute value SHALL be modulo 2^WIDTH: signed MIN / -1 yields quotient MIN, remainder 0, with no exception.
REQ-019 DIVZERO: the next edge SHALL go to END with result_o=0.
REQ-020 END: ready_o=1 and result_o stable; the block SHALL remain in END while start_i=1 and return to IDLE (ready_o=0, result_o=0) on the first edge with start_i=0.
REQ-021 Latency: if start_i is sampled at edge t, ready_o SHALL be high after edge t+WIDTH+1 (t+2 for divide-by-zero).
REQ-022 busy_o SHALL be 1 exactly in DIVZERO and ON.
REQ-023 annul_i=1 in DIVZERO or ON SHALL return to IDLE on that edge, discarding the result; ready_o is never asserted for that operation.
REQ-024 annul_i in END SHALL be ignored; END exits only on start_i=0.
REQ-025 Operand inputs SHALL be ignored outside the IDLE accept edge.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, result_o=0, ready_o=0, busy_o=0, counter=0, in any state, overriding start_i and annul_i.
REQ-027 After rst falls, a start_i held high SHALL be accepted as a fresh operation on the next edge.

Structure
REQ-028 Package ex_div_pkg SHALL hold the state encoding and the default WIDTH constant, shared with the pipeline controller.
REQ-029 A combinational sub-module ex_div_step SHALL implement one shift/trial-subtract iteration (partial remainder, divisor -> next partial remainder, quotient bit).
REQ-030 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=32 unless stated)
REQ-031 Unsigned 100/7 -> quotient 14, remainder 2, ready_o high after edge t+33, busy_o high for 32 cycles.
REQ-032 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-033 5/0 -> result_o 0, ready_o high after edge t+2; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 annul_i pulsed on the 10th ON cycle -> IDLE, ready_o never high; then unsigned 9/3 -> quotient 3, remainder 0.
REQ-035 rst asserted mid-ON -> all outputs 0 on the next edge; WIDTH=8 unsigned 0xFF/0x10 -> quotient 0x0F, remainder 0x0F after edge t+9.
